// File: rtl/ahb_to_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge: one APB setup/access sequence per accepted AHB beat.
// Optional: define AHB_APB_ERR_EN to turn PSLVERR into a two-cycle AHB ERROR response.
module ahb_to_apb_bridge #(
  parameter int HADDR_WIDTH    = 32,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      HSEL,
  input  logic [HADDR_WIDTH-1:0]    HADDR,
  input  logic [1:0]                HTRANS,
  input  logic                      HWRITE,
  input  logic [31:0]               HWDATA,
  input  logic                      HREADY,
  output logic                      HREADYOUT,
  output logic                      HRESP,
  output logic [31:0]               HRDATA,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,
  // FSM state: 0 IDLE, 1 LATCH, 2 SETUP, 3 ACCESS, 4 ERR1, 5 ERR2
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3
`ifdef AHB_APB_ERR_EN
    ,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
`endif
  } state_t;

  state_t state;
  logic   apb_err;
  logic   take;
  logic   unused;

`ifdef AHB_APB_ERR_EN
  assign apb_err = PSLVERR;
`else
  assign apb_err = 1'b0;
`endif

  assign unused = ^{HADDR[HADDR_WIDTH-1:APB_ADDR_WIDTH], HTRANS[0], PSLVERR};

  // A beat is only taken while the bridge itself is signalling ready, so a
  // stalled data phase can never be overtaken by the next address phase.
  assign take = HSEL & HREADY & HTRANS[1] & HREADYOUT;

  always_comb begin
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    HRDATA    = 32'h0;
    case (state)
      ST_IDLE:   HREADYOUT = 1'b1;
      ST_ACCESS: begin
        HREADYOUT = PREADY & ~apb_err;
        if (PREADY) HRDATA = PRDATA;
      end
`ifdef AHB_APB_ERR_EN
      ST_ERR1:   HRESP = 1'b1;
      ST_ERR2:   begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
      end
`endif
      default:   HREADYOUT = 1'b0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_IDLE;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= 32'h0;
      PWRITE  <= 1'b0;
    end else begin
      if (take) begin
        PADDR  <= HADDR[APB_ADDR_WIDTH-1:0];
        PWRITE <= HWRITE;
      end
      case (state)
        ST_IDLE: begin
          if (take) state <= ST_LATCH;
        end
        ST_LATCH: begin
          state <= ST_SETUP;
          PSEL  <= 1'b1;
          if (PWRITE) PWDATA <= HWDATA;
        end
        ST_SETUP: begin
          state   <= ST_ACCESS;
          PENABLE <= 1'b1;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= take ? ST_LATCH : ST_IDLE;
`ifdef AHB_APB_ERR_EN
            if (PSLVERR) state <= ST_ERR1;
`endif
          end
        end
`ifdef AHB_APB_ERR_EN
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= take ? ST_LATCH : ST_IDLE;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule
